sram_arbiter: RTL and testbench

- Single-clock SRAM access arbiter and sequencer between the SRAM pin drivers and the blocks that need memory.
- Downstream side uses the same active-high strobe set the pin drivers expect: ram_addr, ram_din, ram_dout, ram_ce, ram_oe, ram_we, ram_lb, ram_hb.
- Port A is the read-only video fetch port and has priority.
- Port B is a general read/write port (loader/CPU) with a guaranteed grant slot, so video fetch cannot starve it.

---
 rtl/sram_arbiter.sv | 247 ++++++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter and access sequencer in front of the SRAM pin drivers.
//
// Port A is a read-only video fetch port with priority. Port B is a read/write
// loader/CPU port. A burst counter limits how many A grants may be issued in a
// row while B is waiting, so B always gets a slot.
//
// Ports
//   clk, reset_n                  system clock, asynchronous active-low reset
//   a_req/a_addr                  port A read request (held until a_ack)
//   a_ack/a_rdata                 port A one-cycle ack with read data
//   b_req/b_we/b_addr/b_wdata/b_be port B request (held until b_ack)
//   b_ack/b_rdata                 port B one-cycle ack, read data for reads
//   ram_addr/ram_dout             SRAM address and write data
//   ram_din                       SRAM read data, valid while ram_oe is high
//   ram_ce/ram_oe/ram_we          SRAM strobes (active high)
//   ram_lb/ram_hb                 SRAM byte lane enables (active high)
//
// Every output comes straight from a flop. Each access is:
//   grant (IDLE) -> RD_CYCLES x READ -> ack cycle in IDLE (no arbitration)
//   grant (IDLE) -> WR_CYCLES x WRITE -> TURN (b_ack, bus released) -> IDLE

// Protocol checker: exclusive strobes, exclusive acks, address stable under ce.
module sram_arbiter_chk (
  input logic        clk,
  input logic        reset_n,
  input logic        ram_ce,
  input logic        ram_oe,
  input logic        ram_we,
  input logic        a_ack,
  input logic        b_ack,
  input logic [17:0] ram_addr
);

  we_oe_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
    !(ram_we && ram_oe))
    else $error("ram_we and ram_oe asserted together");

  ack_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
    !(a_ack && b_ack))
    else $error("a_ack and b_ack asserted together");

  addr_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (ram_ce && $past(ram_ce)) |-> $stable(ram_addr))
    else $error("ram_addr changed while ram_ce was high");

endmodule

module sram_arbiter #(
  parameter int RD_CYCLES   = 2,
  parameter int WR_CYCLES   = 2,
  parameter int A_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_req,
  input  logic [17:0] a_addr,
  output logic        a_ack,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [17:0] b_addr,
  input  logic [15:0] b_wdata,
  input  logic [1:0]  b_be,
  output logic        b_ack,
  output logic [15:0] b_rdata,
  output logic [17:0] ram_addr,
  input  logic [15:0] ram_din,
  output logic [15:0] ram_dout,
  output logic        ram_ce,
  output logic        ram_oe,
  output logic        ram_we,
  output logic        ram_lb,
  output logic        ram_hb
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_TURN  = 2'd3;

  localparam int CMAX = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int BW   = $clog2(A_BURST_MAX + 1);

  localparam logic [CW-1:0] RD_LAST   = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST   = CW'(WR_CYCLES - 1);
  localparam logic [BW-1:0] BURST_LIM = BW'(A_BURST_MAX);

  logic [1:0]    state_r;
  logic [CW-1:0] cnt_r;
  logic [BW-1:0] burst_r;
  logic          port_b_r;   // 1: current access belongs to port B

  logic          arb_ok_s;
  logic          grant_a_s;
  logic          grant_b_s;

  // Arbitration: only in IDLE and never in a read-ack cycle, where the
  // requester's req is still high from the access being acknowledged.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    arb_ok_s  = (state_r == ST_IDLE) && !a_ack && !b_ack;
    if (!arb_ok_s) begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end else if (a_req && (burst_r < BURST_LIM)) begin
      grant_a_s = 1'b1;
    end else if (b_req) begin
      grant_b_s = 1'b1;
    end else if (a_req) begin
      // A alone is never held off by the burst limit.
      grant_a_s = 1'b1;
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  // Sequencer: state, cycle counter, burst counter and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CW{1'b0}};
      burst_r  <= {BW{1'b0}};
      port_b_r <= 1'b0;
      ram_addr <= 18'h00000;
      ram_dout <= 16'h0000;
      ram_ce   <= 1'b0;
      ram_oe   <= 1'b0;
      ram_we   <= 1'b0;
      ram_lb   <= 1'b0;
      ram_hb   <= 1'b0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_rdata  <= 16'h0000;
      b_rdata  <= 16'h0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          if (grant_a_s) begin
            state_r  <= ST_READ;
            cnt_r    <= {CW{1'b0}};
            port_b_r <= 1'b0;
            ram_addr <= a_addr;
            ram_ce   <= 1'b1;
            ram_oe   <= 1'b1;
            ram_we   <= 1'b0;
            ram_lb   <= 1'b1;
            ram_hb   <= 1'b1;
            // Count consecutive A grants only while B is actually waiting.
            burst_r  <= b_req ? (burst_r + BW'(1)) : {BW{1'b0}};
          end else if (grant_b_s) begin
            cnt_r    <= {CW{1'b0}};
            port_b_r <= 1'b1;
            ram_addr <= b_addr;
            ram_ce   <= 1'b1;
            ram_lb   <= b_be[0];
            ram_hb   <= b_be[1];
            burst_r  <= {BW{1'b0}};
            if (b_we) begin
              state_r  <= ST_WRITE;
              ram_we   <= 1'b1;
              ram_oe   <= 1'b0;
              ram_dout <= b_wdata;
            end else begin
              state_r  <= ST_READ;
              ram_we   <= 1'b0;
              ram_oe   <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_READ: begin
          if (cnt_r == RD_LAST) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            ram_ce  <= 1'b0;
            ram_oe  <= 1'b0;
            ram_we  <= 1'b0;
            ram_lb  <= 1'b0;
            ram_hb  <= 1'b0;
            if (port_b_r) begin
              b_rdata <= ram_din;
              b_ack   <= 1'b1;
            end else begin
              a_rdata <= ram_din;
              a_ack   <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end

        ST_WRITE: begin
          if (cnt_r == WR_LAST) begin
            // Release the bus and ack during the TURN cycle.
            state_r <= ST_TURN;
            cnt_r   <= {CW{1'b0}};
            ram_ce  <= 1'b0;
            ram_oe  <= 1'b0;
            ram_we  <= 1'b0;
            ram_lb  <= 1'b0;
            ram_hb  <= 1'b0;
            b_ack   <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end

        ST_TURN: begin
          state_r <= ST_IDLE;
          b_ack   <= 1'b0;
          a_ack   <= 1'b0;
        end

        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CW{1'b0}};
          ram_ce  <= 1'b0;
          ram_oe  <= 1'b0;
          ram_we  <= 1'b0;
          ram_lb  <= 1'b0;
          ram_hb  <= 1'b0;
          a_ack   <= 1'b0;
          b_ack   <= 1'b0;
        end
      endcase
    end
  end

  sram_arbiter_chk u_chk (
    .clk      (clk),
    .reset_n  (reset_n),
    .ram_ce   (ram_ce),
    .ram_oe   (ram_oe),
    .ram_we   (ram_we),
    .a_ack    (a_ack),
    .b_ack    (b_ack),
    .ram_addr (ram_addr)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  localparam int RD   = 2;
  localparam int WR   = 2;
  localparam int BMAX = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_req;
  logic [17:0] a_addr;
  logic        a_ack;
  logic [15:0] a_rdata;
  logic        b_req;
  logic        b_we;
  logic [17:0] b_addr;
  logic [15:0] b_wdata;
  logic [1:0]  b_be;
  logic        b_ack;
  logic [15:0] b_rdata;
  logic [17:0] ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic        ram_ce, ram_oe, ram_we, ram_lb, ram_hb;

  int n_checks = 0;
  int n_fail   = 0;
  int a_ack_cnt = 0;

  // Pin-level SRAM contents and the bench's expected memory contents.
  logic [15:0] sram_mem [0:262143];
  logic [15:0] ref_mem  [0:262143];

  typedef struct {
    logic        we;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rdata;
    logic [1:0]  exp_lanes;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  sram_arbiter #(.RD_CYCLES(RD), .WR_CYCLES(WR), .A_BURST_MAX(BMAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_ce(ram_ce), .ram_oe(ram_oe), .ram_we(ram_we), .ram_lb(ram_lb), .ram_hb(ram_hb)
  );

  function automatic logic [15:0] init_word(input logic [17:0] addr);
    return addr[15:0] ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] lane_mask(input logic [15:0] d, input logic [1:0] be);
    return {be[1] ? d[15:8] : 8'h00, be[0] ? d[7:0] : 8'h00};
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
    return {be[1] ? n[15:8] : o[15:8], be[0] ? n[7:0] : o[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // SRAM model: writes land mid-cycle while we is high; read data follows oe and lanes.
  initial begin
    forever begin
      @(negedge clk);
      if (ram_ce && ram_we)
        sram_mem[ram_addr] = merge(sram_mem[ram_addr], ram_dout, {ram_hb, ram_lb});
      ram_din = ram_oe ? lane_mask(sram_mem[ram_addr], {ram_hb, ram_lb}) : 16'h0000;
    end
  end

  // Protocol monitor: exclusive strobes/acks, address steady under ce; counts A acks.
  initial begin
    logic        prev_ce;
    logic [17:0] prev_addr;
    prev_ce   = 1'b0;
    prev_addr = 18'h00000;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        n_checks++;
        if ((ram_we && ram_oe) || (a_ack && b_ack) ||
            (prev_ce && ram_ce && (ram_addr !== prev_addr))) begin
          n_fail++;
          $display("FAIL protocol: we=%b oe=%b a_ack=%b b_ack=%b addr=%h prev=%h, expected exclusive we/oe and acks, stable addr",
                   ram_we, ram_oe, a_ack, b_ack, ram_addr, prev_addr);
        end
        if (a_ack) a_ack_cnt++;
        prev_ce   = ram_ce;
        prev_addr = ram_addr;
      end else begin
        prev_ce = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic a_xfer(input logic [17:0] addr, output logic [15:0] rdata, output int lat);
    a_addr = addr;
    a_req  = 1'b1;
    lat    = 0;
    do begin
      tick();
      lat++;
    end while (!a_ack && lat < 200);
    rdata = a_rdata;
    a_req = 1'b0;
    if (!a_ack) check("a_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic b_xfer(input logic we, input logic [17:0] addr, input logic [15:0] wdata,
                        input logic [1:0] be, input bit scramble,
                        output logic [15:0] rdata, output int lat, output int ce_cyc,
                        output logic [1:0] lanes, output bit pins_ok);
    b_we = we; b_addr = addr; b_wdata = wdata; b_be = be; b_req = 1'b1;
    lat = 0; ce_cyc = 0; lanes = 2'b00; pins_ok = 1'b1;
    do begin
      tick();
      lat++;
      // With an idle arbiter the grant happened at this first edge; later input
      // changes must not affect the access.
      if (scramble && lat == 1) begin
        b_we = ~we; b_addr = ~addr; b_wdata = ~wdata; b_be = ~be;
      end
      if (ram_ce && !b_ack) begin
        ce_cyc++;
        lanes = {ram_hb, ram_lb};
        if (ram_addr !== addr || ram_we !== we || ram_oe !== !we || (we && ram_dout !== wdata))
          pins_ok = 1'b0;
      end
      if (b_ack && (ram_ce || ram_oe || ram_we || ram_lb || ram_hb)) pins_ok = 1'b0;
    end while (!b_ack && lat < 200);
    rdata = b_rdata;
    b_req = 1'b0;
    if (!b_ack) check("b_ack_timeout", 32'd0, 32'd1);
    else if (we) ref_mem[addr] = merge(ref_mem[addr], wdata, be);
  endtask

  initial begin
    logic [15:0] rd;
    int          lat, ce_cyc, w;
    logic [1:0]  lanes;
    bit          pins_ok;

    vecs[0] = '{1'b1, 18'h01234, 16'hBEEF, 2'b10, 16'h0000, 2'b10};
    vecs[1] = '{1'b0, 18'h01234, 16'h0000, 2'b11, 16'hBEF7, 2'b11};
    vecs[2] = '{1'b0, 18'h01234, 16'h0000, 2'b01, 16'h00F7, 2'b01};
    vecs[3] = '{1'b1, 18'h00020, 16'h1122, 2'b01, 16'h0000, 2'b01};
    vecs[4] = '{1'b0, 18'h00020, 16'h0000, 2'b11, 16'hA522, 2'b11};
    vecs[5] = '{1'b1, 18'h3FFFF, 16'hABCD, 2'b11, 16'h0000, 2'b11};
    vecs[6] = '{1'b0, 18'h3FFFF, 16'h0000, 2'b11, 16'hABCD, 2'b11};
    vecs[7] = '{1'b1, 18'h00020, 16'hFFFF, 2'b00, 16'h0000, 2'b00};
    vecs[8] = '{1'b0, 18'h00020, 16'h0000, 2'b00, 16'h0000, 2'b00};
    vecs[9] = '{1'b0, 18'h00020, 16'h0000, 2'b11, 16'hA522, 2'b11};

    for (int i = 0; i < 262144; i++) begin
      sram_mem[i] = init_word(18'(i));
      ref_mem[i]  = init_word(18'(i));
    end

    // Reset with a_req held high.
    reset_n = 1'b0;
    a_req = 1'b1; a_addr = 18'h00010;
    b_req = 1'b0; b_we = 1'b0; b_addr = 18'h00000; b_wdata = 16'h0000; b_be = 2'b00;
    repeat (3) tick();
    check("reset_strobes_acks", {25'd0, ram_ce, ram_oe, ram_we, ram_lb, ram_hb, a_ack, b_ack}, 32'd0);
    check("reset_ram_addr", 32'(ram_addr), 32'd0);
    check("reset_ram_dout", 32'(ram_dout), 32'd0);
    check("reset_rdata", {a_rdata, b_rdata}, 32'd0);
    reset_n = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (!a_ack && lat < 50);
    check("first_a_latency", 32'(lat), 32'(RD + 1));
    check("first_a_rdata", 32'(a_rdata), 32'h0000A5D3);
    a_req = 1'b0;
    tick();

    // Table of port-B transactions on an otherwise idle arbiter.
    for (int i = 0; i < 10; i++) begin
      b_xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 1'b1, rd, lat, ce_cyc, lanes, pins_ok);
      check($sformatf("vec%0d_latency", i), 32'(lat), vecs[i].we ? 32'(WR + 1) : 32'(RD + 1));
      check($sformatf("vec%0d_strobe_cycles", i), 32'(ce_cyc), vecs[i].we ? 32'(WR) : 32'(RD));
      check($sformatf("vec%0d_lanes", i), 32'(lanes), 32'(vecs[i].exp_lanes));
      check($sformatf("vec%0d_pins", i), 32'(pins_ok), 32'd1);
      if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
      tick();
    end

    // A alone, req held for 20 accesses: 4 cycles per access after the first.
    a_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      a_addr = 18'h02000 + 18'(k);
      w = 0;
      do begin tick(); w++; end while (!a_ack && w < 50);
      check($sformatf("a_only%0d_interval", k), 32'(w), (k == 0) ? 32'(RD + 1) : 32'(RD + 2));
      check($sformatf("a_only%0d_rdata", k), 32'(a_rdata), 32'(ref_mem[18'h02000 + 18'(k)]));
    end
    a_req = 1'b0;
    tick();

    // Both held continuously: grant order AAAAB AAAAB.
    a_req = 1'b1; a_addr = 18'h02040;
    b_req = 1'b1; b_we = 1'b0; b_addr = 18'h01234; b_be = 2'b11;
    for (int n = 0; n < 10; n++) begin
      w = 0;
      do begin tick(); w++; end while (!a_ack && !b_ack && w < 50);
      check($sformatf("order%0d_is_b", n), 32'(b_ack), (n % 5 == 4) ? 32'd1 : 32'd0);
      if (b_ack) check($sformatf("order%0d_b_rdata", n), 32'(b_rdata), 32'(ref_mem[18'h01234]));
      else       check($sformatf("order%0d_a_rdata", n), 32'(a_rdata), 32'(ref_mem[18'h02040]));
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) tick();

    // Reset in the middle of a write: strobes drop at once, no ack.
    b_we = 1'b1; b_addr = 18'h00150; b_wdata = 16'h5A5A; b_be = 2'b11; b_req = 1'b1;
    w = 0;
    do begin tick(); w++; end while (!ram_we && w < 20);
    check("abort_write_started", 32'(ram_we), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_strobes_dropped", {28'd0, ram_we, ram_ce, ram_lb, ram_hb}, 32'd0);
    b_req = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      check($sformatf("abort_no_ack%0d", n), 32'(b_ack), 32'd0);
    end
    reset_n = 1'b1;
    repeat (2) tick();
    check("abort_no_ack_after", 32'(b_ack), 32'd0);
    b_xfer(1'b1, 18'h00150, 16'h5A5A, 2'b11, 1'b0, rd, lat, ce_cyc, lanes, pins_ok);
    check("retry_write_latency", 32'(lat), 32'(WR + 1));
    tick();
    b_xfer(1'b0, 18'h00150, 16'h0000, 2'b11, 1'b0, rd, lat, ce_cyc, lanes, pins_ok);
    check("retry_readback", 32'(rd), 32'h00005A5A);
    tick();

    // Random traffic on both ports against the reference memory.
    fork
      begin
        logic [15:0] ard;
        logic [17:0] aa;
        int          alat;
        for (int t = 0; t < 1000; t++) begin
          repeat ($urandom_range(0, 3)) tick();
          aa = 18'h02000 + 18'($urandom_range(0, 63));
          a_xfer(aa, ard, alat);
          check("rand_a_rdata", 32'(ard), 32'(ref_mem[aa]));
          a_addr = 18'($urandom);
        end
      end
      begin
        logic [15:0] brd;
        logic [17:0] ba;
        logic        bw;
        logic [1:0]  bbe;
        int          blat, bce, start;
        logic [1:0]  bl;
        bit          bok;
        for (int t = 0; t < 1000; t++) begin
          repeat ($urandom_range(0, 3)) tick();
          bw  = 1'($urandom);
          bbe = 2'($urandom);
          if (bw || ($urandom_range(0, 1) == 0)) ba = 18'h00100 + 18'($urandom_range(0, 63));
          else ba = 18'h02000 + 18'($urandom_range(0, 63));
          start = a_ack_cnt;
          b_xfer(bw, ba, 16'($urandom), bbe, 1'b0, brd, blat, bce, bl, bok);
          n_checks++;
          if (a_ack_cnt - start > BMAX + 1) begin
            n_fail++;
            $display("FAIL rand_b_starvation: %0d A accesses while B waited, at most %0d allowed",
                     a_ack_cnt - start, BMAX + 1);
          end
          if (!bw) check("rand_b_rdata", 32'(brd), 32'(lane_mask(ref_mem[ba], bbe)));
        end
      end
    join

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
